video_mnist_frame_ctrl: RTL

- Frame-synchronous control and statistics block for the MNIST CNN validation video path.
- Holds WISHBONE-writable shadow copies of the threshold, invert and color-mode parameters.
- Commits the shadow copies to the active parameter outputs only at a start-of-frame beat, so the datapath never sees a mid-frame change.
- Taps the validation output stream (monitor only, never drives tready) to report frame count and per-frame validated/total beat counts.

---
 rtl/video_mnist_frame_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/video_mnist_frame_ctrl.sv
// video_mnist_frame_ctrl: frame-synchronous parameter commit and stream statistics with a WISHBONE register bank
module video_mnist_frame_ctrl #(
    parameter int                      DATA_WIDTH      = 8,
    parameter int                      MODE_WIDTH      = 2,
    parameter int                      COUNT_WIDTH     = 32,
    parameter int                      WB_ADR_WIDTH    = 8,
    parameter int                      WB_DAT_WIDTH    = 32,
    parameter int                      WB_SEL_WIDTH    = WB_DAT_WIDTH / 8,
    parameter logic [31:0]             CORE_ID         = 32'h527a_2310,
    parameter logic [DATA_WIDTH-1:0]   INIT_PARAM_TH   = 127,
    parameter logic                    INIT_PARAM_INV  = 1'b0,
    parameter logic [MODE_WIDTH-1:0]   INIT_PARAM_MODE = 2'b10
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic                    s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_stb_i,
    output logic                    s_wb_ack_o,
    input  logic                    mon_tuser,
    input  logic                    mon_tvalidation,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,
    output logic [DATA_WIDTH-1:0]   param_th,
    output logic                    param_inv,
    output logic [MODE_WIDTH-1:0]   param_mode,
    output logic                    frame_start
);

    typedef enum logic {IDLE, FRAME} state_t;

    localparam logic [WB_ADR_WIDTH-1:0] A_ID    = 'h00;
    localparam logic [WB_ADR_WIDTH-1:0] A_CTRL  = 'h04;
    localparam logic [WB_ADR_WIDTH-1:0] A_STAT  = 'h05;
    localparam logic [WB_ADR_WIDTH-1:0] A_S_TH  = 'h08;
    localparam logic [WB_ADR_WIDTH-1:0] A_S_INV = 'h09;
    localparam logic [WB_ADR_WIDTH-1:0] A_S_MOD = 'h0a;
    localparam logic [WB_ADR_WIDTH-1:0] A_FCNT  = 'h10;
    localparam logic [WB_ADR_WIDTH-1:0] A_VCNT  = 'h11;
    localparam logic [WB_ADR_WIDTH-1:0] A_BCNT  = 'h12;
    localparam logic [WB_ADR_WIDTH-1:0] A_A_TH  = 'h18;
    localparam logic [WB_ADR_WIDTH-1:0] A_A_INV = 'h19;
    localparam logic [WB_ADR_WIDTH-1:0] A_A_MOD = 'h1a;

    state_t                  state, state_nxt;
    logic                    in_frame, beat, sof, wr, commit, upd_set;
    logic                    update_pending, auto_update;
    logic [DATA_WIDTH-1:0]   sh_th;
    logic                    sh_inv;
    logic [MODE_WIDTH-1:0]   sh_mode;
    logic [COUNT_WIDTH-1:0]  run_valid, run_beat, frame_count, valid_count, beat_count;
    logic [WB_DAT_WIDTH-1:0] wmask, th_wr, inv_wr, mode_wr;
    logic                    unused_ok;

    assign beat       = mon_tvalid & mon_tready;
    assign sof        = beat & mon_tuser;
    assign wr         = s_wb_stb_i & s_wb_we_i;
    assign in_frame   = state == FRAME;
    assign commit     = sof & (update_pending | auto_update);
    assign upd_set    = wr & (s_wb_adr_i == A_CTRL) & wmask[0] & s_wb_dat_i[0];
    assign s_wb_ack_o = s_wb_stb_i;
    assign th_wr      = (WB_DAT_WIDTH'(sh_th) & ~wmask) | (s_wb_dat_i & wmask);
    assign inv_wr     = (WB_DAT_WIDTH'(sh_inv) & ~wmask) | (s_wb_dat_i & wmask);
    assign mode_wr    = (WB_DAT_WIDTH'(sh_mode) & ~wmask) | (s_wb_dat_i & wmask);
    assign unused_ok  = ^{th_wr, inv_wr, mode_wr};

    // expand byte selects into a per-bit write mask
    always_comb begin
        wmask = '0;
        for (int i = 0; i < WB_SEL_WIDTH; i++) wmask[i*8 +: 8] = {8{s_wb_sel_i[i]}};
    end

    // the frame FSM leaves IDLE on the first SOF and never returns
    always_comb begin
        state_nxt = sof ? FRAME : state;
    end

    // state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // shadow writes, control bits and the SOF-aligned commit into the active set
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sh_th          <= INIT_PARAM_TH;
            sh_inv         <= INIT_PARAM_INV;
            sh_mode        <= INIT_PARAM_MODE;
            param_th       <= INIT_PARAM_TH;
            param_inv      <= INIT_PARAM_INV;
            param_mode     <= INIT_PARAM_MODE;
            update_pending <= 1'b0;
            auto_update    <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            if (commit) begin
                param_th   <= sh_th;
                param_inv  <= sh_inv;
                param_mode <= sh_mode;
            end
            if (wr && s_wb_adr_i == A_S_TH)  sh_th   <= th_wr[DATA_WIDTH-1:0];
            if (wr && s_wb_adr_i == A_S_INV) sh_inv  <= inv_wr[0];
            if (wr && s_wb_adr_i == A_S_MOD) sh_mode <= mode_wr[MODE_WIDTH-1:0];
            if (wr && s_wb_adr_i == A_CTRL && wmask[1]) auto_update <= s_wb_dat_i[1];
            update_pending <= upd_set ? 1'b1 : (commit ? 1'b0 : update_pending);
            frame_start    <= sof;
        end
    end

    // per-frame beat statistics, latched at each SOF once a frame has started
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_valid   <= '0;
            run_beat    <= '0;
            frame_count <= '0;
            valid_count <= '0;
            beat_count  <= '0;
        end else if (sof) begin
            run_beat    <= COUNT_WIDTH'(1);
            run_valid   <= COUNT_WIDTH'(mon_tvalidation);
            frame_count <= frame_count + COUNT_WIDTH'(1);
            if (in_frame) begin
                valid_count <= run_valid;
                beat_count  <= run_beat;
            end
        end else if (beat) begin
            run_beat <= &run_beat ? run_beat : run_beat + COUNT_WIDTH'(1);
            if (mon_tvalidation && !(&run_valid)) run_valid <= run_valid + COUNT_WIDTH'(1);
        end
    end

    // combinational register read mux
    always_comb begin
        s_wb_dat_o = '0;
        case (s_wb_adr_i)
            A_ID:    s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            A_CTRL:  s_wb_dat_o = WB_DAT_WIDTH'({auto_update, update_pending});
            A_STAT:  s_wb_dat_o = WB_DAT_WIDTH'({in_frame, update_pending});
            A_S_TH:  s_wb_dat_o = WB_DAT_WIDTH'(sh_th);
            A_S_INV: s_wb_dat_o = WB_DAT_WIDTH'(sh_inv);
            A_S_MOD: s_wb_dat_o = WB_DAT_WIDTH'(sh_mode);
            A_FCNT:  s_wb_dat_o = WB_DAT_WIDTH'(frame_count);
            A_VCNT:  s_wb_dat_o = WB_DAT_WIDTH'(valid_count);
            A_BCNT:  s_wb_dat_o = WB_DAT_WIDTH'(beat_count);
            A_A_TH:  s_wb_dat_o = WB_DAT_WIDTH'(param_th);
            A_A_INV: s_wb_dat_o = WB_DAT_WIDTH'(param_inv);
            A_A_MOD: s_wb_dat_o = WB_DAT_WIDTH'(param_mode);
            default: s_wb_dat_o = '0;
        endcase
    end

endmodule
